// File: rtl/pipeline_sink_pkg.sv
// Shared definitions for the pipeline sink: FSM state encoding, default
// sizes and a saturating increment used by the event counters.
package pipeline_sink_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        CHECK = 2'd1,
        FLUSH = 2'd2
    } sink_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sink_fifo.sv
// Small circular FIFO for the pipeline sink. clear empties it in one cycle
// and takes priority over a write or read in the same cycle. The caller never
// writes when full nor reads when empty.
module sink_fifo
    import pipeline_sink_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     clear,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // No bypass: the head is always read from storage.
    assign rd_data = mem[rd_ptr];

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_sink.sv
// Terminal stage of a pipeline: buffers beats in a FIFO, checks that the
// accepted data forms an incrementing sequence, and counts beats, flushes
// and sequence errors.
//
// Handshakes: upstream offers a beat with in_valid and must hold it while
// out_stall is high; a beat is taken on a rising edge where in_valid is high,
// out_stall is low and no flush is in progress. Downstream takes the head beat
// on a rising edge where out_valid and out_ready are both high. out_stall only
// depends on registered state, so it has no combinational path from inputs.
module pipeline_sink
    import pipeline_sink_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_flush,
    output logic             out_stall,
    input  logic             chk_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] beat_count,
    output logic [7:0]       flush_count,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);

    sink_state_t      state;
    logic [WIDTH-1:0] expected;
    logic [AW:0]      count;
    logic             accept;
    logic             dequeue;

    assign out_stall = (count == (AW+1)'(DEPTH)) | (state == FLUSH);
    assign out_valid = (count != '0);
    assign accept    = in_valid & ~out_stall & ~in_flush & (state != FLUSH);
    // A flush in the same cycle cancels the consumer's read.
    assign dequeue   = out_valid & out_ready & ~in_flush;
    assign dbg_state = state;

    sink_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (in_data),
        .rd_en   (dequeue),
        .clear   (in_flush),
        .rd_data (out_data),
        .count   (count)
    );

    // Sequence FSM, checker and event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC;
            expected    <= '0;
            err         <= 1'b0;
            err_count   <= '0;
            beat_count  <= '0;
            flush_count <= '0;
        end else if (in_flush) begin
            state       <= FLUSH;
            flush_count <= 8'(sat_inc(32'(flush_count), 8));
        end else begin
            if (accept) begin
                beat_count <= CNT_W'(sat_inc(32'(beat_count), CNT_W));
                expected   <= in_data + 1'b1;
            end
            case (state)
                SYNC: begin
                    if (accept) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (accept && chk_en && (in_data != expected)) begin
                        err       <= 1'b1;
                        err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule
